// File: rtl/rf_write_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_write_ctrl_if
// Purpose  : Bundles the writeback request, debug/loader handshake, register
//            file write-port and status signals of rf_write_ctrl.
// Modports : master - requester side (drives wb_* and dbg_valid/addr/data,
//                     observes dbg_ready, rf_*, cpu_hold, init_done, hold_err)
//            slave  - the controller (the reverse directions)
// Params   : DATA_W register data width, ADDR_W register address width
// Revision : 1.0 - initial release
// ============================================================================
interface rf_write_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              dbg_valid;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ready;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              cpu_hold;
  logic              init_done;
  logic              hold_err;

  modport master (
    output wb_we, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    input  dbg_ready, rf_we, rf_waddr, rf_wdata, cpu_hold, init_done, hold_err
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, dbg_valid, dbg_addr, dbg_data,
    output dbg_ready, rf_we, rf_waddr, rf_wdata, cpu_hold, init_done, hold_err
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rf_write_ctrl
// Purpose  : Shares the single register-file write port between the pipeline
//            writeback stage (highest priority) and a debug/loader port.
//            Writes to register 0 are suppressed. A debug request blocked for
//            STARVE_LIMIT consecutive cycles raises cpu_hold so the pipeline
//            yields the port. hold_err is sticky when writeback ignores hold.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - rf_write_ctrl_if.slave (writeback, debug handshake,
//                   register-file write port, cpu_hold/init_done/hold_err)
// Config   : RF_INIT_CLEAR_EN - when defined, every register is swept to
//            zero after reset (INIT state) before normal operation begins.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  wire logic       clk,
  input  wire logic       rst,
  rf_write_ctrl_if.slave  bus
);

  localparam int NREG     = 2 ** ADDR_W;
  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic                r_holdErr;
  logic [STARVE_W-1:0] r_starveCnt;
  logic                w_inInit;
  logic [ADDR_W-1:0]   w_initAddr;
  logic                w_dbgReady;
  logic                w_rfWe;
  logic [ADDR_W-1:0]   w_rfWaddr;
  logic [DATA_W-1:0]   w_rfWdata;
  logic                w_cpuHold;
  logic                w_initDone;

`ifdef RF_INIT_CLEAR_EN
  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [ADDR_W-1:0] r_initCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_initCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == S_INIT) r_initCnt <= r_initCnt + ADDR_W'(1);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (r_state == S_INIT && r_initCnt == ADDR_W'(NREG - 1)) w_stateNext = S_RUN;
  end

  assign w_inInit   = (r_state == S_INIT);
  assign w_initAddr = r_initCnt;
`else
  // Without the clear sweep the block is permanently in its run behaviour.
  assign w_inInit   = 1'b0;
  assign w_initAddr = '0;
`endif

  // Write-port mux: writeback first, then debug. Register 0 is hard-wired,
  // so its writes are dropped at the port while the transfer still completes.
  always_comb begin
    w_dbgReady = 1'b0;
    w_rfWe     = 1'b0;
    w_rfWaddr  = '0;
    w_rfWdata  = '0;
    w_cpuHold  = (r_starveCnt == STARVE_MAX);
    w_initDone = 1'b1;
    if (w_inInit) begin
      w_rfWe     = 1'b1;
      w_rfWaddr  = w_initAddr;
      w_cpuHold  = 1'b1;
      w_initDone = 1'b0;
    end else begin
      w_dbgReady = bus.dbg_valid & ~bus.wb_we;
      if (bus.wb_we) begin
        w_rfWe    = |bus.wb_addr;
        w_rfWaddr = bus.wb_addr;
        w_rfWdata = bus.wb_data;
      end else if (bus.dbg_valid) begin
        w_rfWe    = |bus.dbg_addr;
        w_rfWaddr = bus.dbg_addr;
        w_rfWdata = bus.dbg_data;
      end
    end
  end

  // Consecutive-blocked-cycle counter; saturation is what raises cpu_hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starveCnt <= '0;
    end else if (w_inInit) begin
      r_starveCnt <= '0;
    end else if (bus.dbg_valid & ~w_dbgReady) begin
      if (r_starveCnt != STARVE_MAX) r_starveCnt <= r_starveCnt + STARVE_W'(1);
    end else begin
      r_starveCnt <= '0;
    end
  end

  // Sticky protocol-violation flag: writeback issued while told to hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_holdErr <= 1'b0;
    end else if (bus.wb_we & w_cpuHold) begin
      r_holdErr <= 1'b1;
    end
  end

  assign bus.dbg_ready = w_dbgReady;
  assign bus.rf_we     = w_rfWe;
  assign bus.rf_waddr  = w_rfWaddr;
  assign bus.rf_wdata  = w_rfWdata;
  assign bus.cpu_hold  = w_cpuHold;
  assign bus.init_done = w_initDone;
  assign bus.hold_err  = r_holdErr;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_ctrl
// Purpose  : Self-checking bench for rf_write_ctrl. Directed scenarios (sweep,
//            priority, register 0, starvation, hold violation, mid-sweep
//            reset) plus a randomized phase, all checked every cycle against
//            a behavioural model of the port-sharing rules.
// Config   : follows RF_INIT_CLEAR_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_ctrl;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 8;
  localparam int NREG         = 32;
`ifdef RF_INIT_CLEAR_EN
  localparam bit HAS_INIT = 1'b1;
`else
  localparam bit HAS_INIT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_write_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nChecks = 0;
  int nErrors = 0;
  int cyc     = 0;

  // Behavioural model: sweep position, length of the current blocked-debug
  // streak, and the sticky violation flag.
  bit mInit;
  int mSweep;
  int mStreak;
  bit mHerr;
  bit lastReady;

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit modelHold();
    return mInit || (mStreak >= STARVE_LIMIT);
  endfunction

  task automatic modelReset();
    mInit   = HAS_INIT;
    mSweep  = 0;
    mStreak = 0;
    mHerr   = 1'b0;
  endtask

  task automatic drive(input bit we, input int wa, input logic [31:0] wd,
                       input bit dv, input int da, input logic [31:0] dd);
    bus.wb_we     = we;
    bus.wb_addr   = ADDR_W'(wa);
    bus.wb_data   = wd;
    bus.dbg_valid = dv;
    bus.dbg_addr  = ADDR_W'(da);
    bus.dbg_data  = dd;
  endtask

  // One clock cycle: check outputs against the model mid-cycle, then advance
  // the model across the rising edge.
  task automatic cycle();
    bit                eWe, eReady, eHold, eDone, idle;
    logic [ADDR_W-1:0] eAddr;
    logic [DATA_W-1:0] eData;
    #2;
    eHold  = modelHold();
    eDone  = !mInit;
    eReady = 1'b0;
    eWe    = 1'b0;
    idle   = 1'b0;
    eAddr  = '0;
    eData  = '0;
    if (mInit) begin
      eWe   = 1'b1;
      eAddr = ADDR_W'(mSweep);
    end else begin
      eReady = bus.dbg_valid && !bus.wb_we;
      if (bus.wb_we) begin
        eWe = (bus.wb_addr != 0); eAddr = bus.wb_addr; eData = bus.wb_data;
      end else if (bus.dbg_valid) begin
        eWe = (bus.dbg_addr != 0); eAddr = bus.dbg_addr; eData = bus.dbg_data;
      end else begin
        idle = 1'b1;
      end
    end
    checkValue("rf_we", bus.rf_we, eWe);
    if (eWe || idle) begin
      checkValue("rf_waddr", bus.rf_waddr, eAddr);
      checkValue("rf_wdata", bus.rf_wdata, eData);
    end
    checkValue("dbg_ready", bus.dbg_ready, eReady);
    checkValue("cpu_hold", bus.cpu_hold, eHold);
    checkValue("init_done", bus.init_done, eDone);
    checkValue("hold_err", bus.hold_err, mHerr);
    lastReady = eReady;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (bus.wb_we && eHold) mHerr = 1'b1;
      if (mInit) begin
        mSweep++;
        if (mSweep == NREG) mInit = 1'b0;
      end else if (bus.dbg_valid && !eReady) begin
        mStreak = (mStreak < STARVE_LIMIT) ? mStreak + 1 : STARVE_LIMIT;
      end else begin
        mStreak = 0;
      end
    end
    #1;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    modelReset();
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit          pend;
    int          pa;
    logic [31:0] pd;
    bit          wbe;

    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    applyReset();

    // Sweep (or immediate run without the sweep), then settle.
    idleCycles(HAS_INIT ? NREG + 2 : 2);
    checkValue("init_done_after", bus.init_done, 1'b1);

    // Priority: writeback beats debug, then debug gets the port.
    drive(1, 5, 32'hAAAA0001, 1, 6, 32'h12345678);
    #1;
    checkValue("prio_wb_addr", bus.rf_waddr, 5);
    cycle();
    drive(0, 0, 0, 1, 6, 32'h12345678);
    #1;
    checkValue("prio_dbg_addr", bus.rf_waddr, 6);
    checkValue("prio_dbg_ready", bus.dbg_ready, 1'b1);
    cycle();

    // Register 0 from both sources.
    drive(1, 0, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 1, 0, 32'hCAFEF00D);
    #1;
    checkValue("r0_dbg_ready", bus.dbg_ready, 1'b1);
    checkValue("r0_dbg_we", bus.rf_we, 1'b0);
    cycle();
    idleCycles(1);

    // Starvation: writeback holds the port for STARVE_LIMIT cycles.
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      drive(1, 9 + (i % 4), 32'h100 + i, 1, 7, 32'h0BADC0DE);
      cycle();
    end
    drive(0, 0, 0, 1, 7, 32'h0BADC0DE);
    #1;
    checkValue("starve_hold", bus.cpu_hold, 1'b1);
    checkValue("starve_grant", bus.dbg_ready, 1'b1);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    checkValue("starve_release", bus.cpu_hold, 1'b0);
    cycle();

    // Randomized traffic that honours cpu_hold and the debug handshake.
    pend = 1'b0;
    pa   = 0;
    pd   = '0;
    for (int i = 0; i < 500; i++) begin
      if (pend && $urandom_range(15) == 0) begin
        pend = 1'b0;
      end else if (!pend && $urandom_range(2) != 0) begin
        pend = 1'b1;
        pa   = $urandom_range(NREG - 1);
        pd   = $urandom;
      end
      wbe = !modelHold() && ($urandom_range(3) != 0);
      drive(wbe, $urandom_range(NREG - 1), $urandom, pend, pa, pd);
      cycle();
      if (pend && lastReady) pend = 1'b0;
    end
    idleCycles(1);

    // Hold violation: writeback keeps going after hold is raised.
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      drive(1, 12, 32'h55 + i, 1, 13, 32'h13131313);
      cycle();
    end
    drive(1, 3, 32'h33333333, 1, 13, 32'h13131313);
    #1;
    checkValue("viol_wb_wins", bus.rf_waddr, 3);
    cycle();
    drive(1, 4, 32'h44444444, 1, 13, 32'h13131313);
    #1;
    checkValue("viol_hold_stays", bus.cpu_hold, 1'b1);
    cycle();
    idleCycles(3);
    checkValue("viol_sticky", bus.hold_err, 1'b1);

    // Mid-sweep reset (plain reset when the sweep is absent).
    applyReset();
    idleCycles(17);
    applyReset();
    checkValue("rst_clears_err", bus.hold_err, 1'b0);
    idleCycles(HAS_INIT ? NREG + 2 : 2);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
